// File: rtl/dpsram_if.sv
// Request/response bundle for the dual-port SRAM: one write port and one read port.
// The memory is the slave side; a requester uses the master side.
interface dpsram_if #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
);
  logic                   i_wr_cen;
  logic [BW_ADDR-1:0]     i_wr_addr;
  logic [BW_DATA-1:0]     i_wr_data;
  logic [BW_DATA/8-1:0]   i_wr_be;
  logic                   i_rd_cen;
  logic [BW_ADDR-1:0]     i_rd_addr;
  logic [BW_DATA-1:0]     o_rd_data;
  logic                   o_rd_valid;
  logic                   o_init_busy;

  modport master (
    output i_wr_cen, i_wr_addr, i_wr_data, i_wr_be, i_rd_cen, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_init_busy
  );

  modport slave (
    input  i_wr_cen, i_wr_addr, i_wr_data, i_wr_be, i_rd_cen, i_rd_addr,
    output o_rd_data, o_rd_valid, o_init_busy
  );
endinterface

// File: rtl/dpsram.sv
// Simple dual-port SRAM with byte enables, a post-reset clear sweep, selectable
// read latency (1 or 2) and selectable read-during-write policy.
module dpsram #(
  parameter int BW_DATA  = 32,
  parameter int BW_ADDR  = 5,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 1
) (
  input  logic     i_clk,
  input  logic     i_rstn,
  dpsram_if.slave  bus
);
  localparam int DEPTH = 2**BW_ADDR;
  localparam int NB    = BW_DATA / 8;

  typedef enum logic {INIT, READY} state_t;

  state_t               state_reg;
  logic [BW_ADDR-1:0]   clr_cnt_reg;
  logic                 init_busy_reg;
  logic                 rd_valid_reg;
  logic                 in_init;
  logic                 wr_en;
  logic                 rd_en;
  logic                 same_addr;
  logic [BW_ADDR-1:0]   mem_addr;
  logic [BW_DATA-1:0]   rd_word;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg     <= INIT;
      clr_cnt_reg   <= '0;
      init_busy_reg <= 1'b1;
    end else begin
      case (state_reg)
        INIT: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == {BW_ADDR{1'b1}}) begin
            state_reg     <= READY;
            init_busy_reg <= 1'b0;
          end
        end
        READY: begin
          state_reg <= READY;
        end
      endcase
    end
  end

  assign in_init   = (state_reg == INIT);
  assign wr_en     = !in_init && bus.i_wr_cen;
  assign rd_en     = !in_init && bus.i_rd_cen;
  assign same_addr = wr_en && (bus.i_wr_addr == bus.i_rd_addr);
  // The clear sweep borrows the write port, so user requests are simply masked.
  assign mem_addr  = in_init ? clr_cnt_reg : bus.i_wr_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] wr_byte;
      logic       lane_we;
      logic [7:0] rd_byte_reg;

      assign wr_byte = in_init ? 8'h00 : bus.i_wr_data[8*gi +: 8];
      assign lane_we = in_init || (wr_en && bus.i_wr_be[gi]);

      always_ff @(posedge i_clk) begin
        if (lane_we)
          mem[mem_addr] <= wr_byte;
      end

      // Array read returns pre-write contents; forwarding gives the new-data policy.
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          rd_byte_reg <= '0;
        end else if (rd_en) begin
          if ((WR_FIRST != 0) && same_addr && bus.i_wr_be[gi])
            rd_byte_reg <= wr_byte;
          else
            rd_byte_reg <= mem[bus.i_rd_addr];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      rd_valid_reg <= 1'b0;
    else
      rd_valid_reg <= rd_en;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [BW_DATA-1:0] out_data_reg;
      logic               out_valid_reg;

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          out_data_reg  <= '0;
          out_valid_reg <= 1'b0;
        end else begin
          out_valid_reg <= rd_valid_reg;
          if (rd_valid_reg)
            out_data_reg <= rd_word;
        end
      end

      assign bus.o_rd_data  = out_data_reg;
      assign bus.o_rd_valid = out_valid_reg;
    end else begin : g_lat1
      assign bus.o_rd_data  = rd_word;
      assign bus.o_rd_valid = rd_valid_reg;
    end
  endgenerate

  assign bus.o_init_busy = init_busy_reg;
endmodule

// File: tb/tb_dpsram.sv
// Directed bench: dut_a uses defaults (RD_LAT=1, WR_FIRST=1), dut_b uses
// RD_LAT=2, WR_FIRST=0; both see identical stimulus.
module tb_dpsram;
  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        wr_cen;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_cen;
  logic [4:0]  rd_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [32];

  always #5 i_clk = ~i_clk;

  dpsram_if #(.BW_DATA(32), .BW_ADDR(5)) bus_a ();
  dpsram_if #(.BW_DATA(32), .BW_ADDR(5)) bus_b ();

  assign bus_a.i_wr_cen  = wr_cen;
  assign bus_a.i_wr_addr = wr_addr;
  assign bus_a.i_wr_data = wr_data;
  assign bus_a.i_wr_be   = wr_be;
  assign bus_a.i_rd_cen  = rd_cen;
  assign bus_a.i_rd_addr = rd_addr;
  assign bus_b.i_wr_cen  = wr_cen;
  assign bus_b.i_wr_addr = wr_addr;
  assign bus_b.i_wr_data = wr_data;
  assign bus_b.i_wr_be   = wr_be;
  assign bus_b.i_rd_cen  = rd_cen;
  assign bus_b.i_rd_addr = rd_addr;

  dpsram dut_a (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus_a)
  );

  dpsram #(.RD_LAT(2), .WR_FIRST(0)) dut_b (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus_b)
  );

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_cen = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_cen = 1'b0;
  endtask

  // Single read; a-side result after one edge, b-side after two.
  task automatic read_one(input logic [4:0] a,
                          output logic [32:0] ra, output logic [32:0] rb,
                          output logic [32:0] ra_next);
    rd_cen = 1'b1; rd_addr = a;
    step();
    rd_cen = 1'b0;
    ra = {bus_a.o_rd_valid, bus_a.o_rd_data};
    step();
    rb      = {bus_b.o_rd_valid, bus_b.o_rd_data};
    ra_next = {bus_a.o_rd_valid, bus_a.o_rd_data};
  endtask

  // Release reset and count busy cycles per DUT, optionally issuing requests throughout.
  task automatic release_sweep(input bit with_req, output int cnt_a, output int cnt_b,
                               output int pulses);
    cnt_a = 0; cnt_b = 0; pulses = 0;
    if (with_req) begin
      wr_cen = 1'b1; wr_addr = 5'd1; wr_data = 32'h5; wr_be = 4'hF;
      rd_cen = 1'b1; rd_addr = 5'd1;
    end
    i_rstn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus_a.o_init_busy) cnt_a++;
      if (bus_b.o_init_busy) cnt_b++;
      if (!bus_a.o_init_busy && !bus_b.o_init_busy) begin
        wr_cen = 1'b0; rd_cen = 1'b0;
      end
      step();
      if (bus_a.o_rd_valid || bus_b.o_rd_valid) pulses++;
    end
    wr_cen = 1'b0; rd_cen = 1'b0;
  endtask

  task automatic test_reset;
    int ca, cb, vp;
    $display("test_reset");
    i_rstn = 1'b0; wr_cen = 1'b0; rd_cen = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    repeat (3) step();
    checks++;
    if ({bus_a.o_rd_valid, bus_a.o_init_busy, bus_a.o_rd_data} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL reset_a got %b/%b/%h want 0/1/0", bus_a.o_rd_valid, bus_a.o_init_busy, bus_a.o_rd_data);
    end
    checks++;
    if ({bus_b.o_rd_valid, bus_b.o_init_busy, bus_b.o_rd_data} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL reset_b got %b/%b/%h want 0/1/0", bus_b.o_rd_valid, bus_b.o_init_busy, bus_b.o_rd_data);
    end
    release_sweep(1'b1, ca, cb, vp);
    checks++;
    if (ca !== 32) begin errors++; $display("FAIL busy_len_a got %0d want 32", ca); end
    checks++;
    if (cb !== 32) begin errors++; $display("FAIL busy_len_b got %0d want 32", cb); end
    checks++;
    if (vp !== 0) begin errors++; $display("FAIL init_valid got %0d pulses want 0", vp); end
  endtask

  task automatic test_init_requests;
    logic [32:0] ra, rb, ran;
    $display("test_init_requests");
    read_one(5'd1, ra, rb, ran);
    checks++;
    if (ra !== {1'b1, 32'h0}) begin errors++; $display("FAIL init_req_a got %h want 100000000", ra); end
    checks++;
    if (rb !== {1'b1, 32'h0}) begin errors++; $display("FAIL init_req_b got %h want 100000000", rb); end
  endtask

  // Back-to-back reads of every address, checked against exp_mem on both DUTs.
  task automatic test_back_to_back(input string tag);
    logic [32:0] ea, eb;
    $display("test_back_to_back %s", tag);
    for (int c = 0; c < 34; c++) begin
      if (c < 32) begin rd_cen = 1'b1; rd_addr = 5'(c); end
      else rd_cen = 1'b0;
      step();
      if (c < 32) ea = {1'b1, exp_mem[c]};
      else        ea = {1'b0, exp_mem[31]};
      checks++;
      if ({bus_a.o_rd_valid, bus_a.o_rd_data} !== ea) begin
        errors++; $display("FAIL %s_a cyc %0d got %h want %h", tag, c, {bus_a.o_rd_valid, bus_a.o_rd_data}, ea);
      end
      if (c == 0) begin
        checks++;
        if (bus_b.o_rd_valid !== 1'b0) begin
          errors++; $display("FAIL %s_b early valid got %b want 0", tag, bus_b.o_rd_valid);
        end
      end else begin
        if (c <= 32) eb = {1'b1, exp_mem[c-1]};
        else         eb = {1'b0, exp_mem[31]};
        checks++;
        if ({bus_b.o_rd_valid, bus_b.o_rd_data} !== eb) begin
          errors++; $display("FAIL %s_b cyc %0d got %h want %h", tag, c, {bus_b.o_rd_valid, bus_b.o_rd_data}, eb);
        end
      end
    end
  endtask

  task automatic test_byte_enables;
    logic [32:0] ra, rb, ran;
    $display("test_byte_enables");
    do_write(5'd3, 32'hAABBCCDD, 4'b1111);
    do_write(5'd3, 32'h11223344, 4'b0101);
    do_write(5'd3, 32'hFFFFFFFF, 4'b0000);
    read_one(5'd3, ra, rb, ran);
    checks++;
    if (ra !== {1'b1, 32'hAA22CC44}) begin errors++; $display("FAIL be_a got %h want 1aa22cc44", ra); end
    checks++;
    if (rb !== {1'b1, 32'hAA22CC44}) begin errors++; $display("FAIL be_b got %h want 1aa22cc44", rb); end
    checks++;
    if (ran !== {1'b0, 32'hAA22CC44}) begin errors++; $display("FAIL hold_a got %h want 0aa22cc44", ran); end
  endtask

  task automatic test_rdw;
    logic [32:0] ra, rb, ran;
    $display("test_rdw");
    wr_cen = 1'b1; wr_addr = 5'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
    rd_cen = 1'b1; rd_addr = 5'd7;
    step();
    wr_cen = 1'b0; rd_cen = 1'b0;
    checks++;
    if ({bus_a.o_rd_valid, bus_a.o_rd_data} !== {1'b1, 32'h0000FFFF}) begin
      errors++; $display("FAIL rdw_new_a got %h want 10000ffff", {bus_a.o_rd_valid, bus_a.o_rd_data});
    end
    step();
    checks++;
    if ({bus_b.o_rd_valid, bus_b.o_rd_data} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rdw_old_b got %h want 100000000", {bus_b.o_rd_valid, bus_b.o_rd_data});
    end
    wr_cen = 1'b1; wr_addr = 5'd8; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_cen = 1'b1; rd_addr = 5'd9;
    step();
    wr_cen = 1'b0; rd_cen = 1'b0;
    checks++;
    if ({bus_a.o_rd_valid, bus_a.o_rd_data} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rdw_diff_a got %h want 100000000", {bus_a.o_rd_valid, bus_a.o_rd_data});
    end
    step();
    read_one(5'd7, ra, rb, ran);
    checks++;
    if (ra !== {1'b1, 32'h0000FFFF}) begin errors++; $display("FAIL rdw_after_a got %h want 10000ffff", ra); end
    checks++;
    if (rb !== {1'b1, 32'h0000FFFF}) begin errors++; $display("FAIL rdw_after_b got %h want 10000ffff", rb); end
    read_one(5'd8, ra, rb, ran);
    checks++;
    if (rb !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL rdw_addr8_b got %h want 112345678", rb); end
  endtask

  task automatic test_inflight_write;
    logic [32:0] ra, rb, ran;
    $display("test_inflight_write");
    rd_cen = 1'b1; rd_addr = 5'd3;
    step();
    rd_cen = 1'b0;
    checks++;
    if ({bus_a.o_rd_valid, bus_a.o_rd_data} !== {1'b1, 32'hAA22CC44}) begin
      errors++; $display("FAIL inflight_a got %h want 1aa22cc44", {bus_a.o_rd_valid, bus_a.o_rd_data});
    end
    wr_cen = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    step();
    wr_cen = 1'b0;
    checks++;
    if ({bus_b.o_rd_valid, bus_b.o_rd_data} !== {1'b1, 32'hAA22CC44}) begin
      errors++; $display("FAIL inflight_b got %h want 1aa22cc44", {bus_b.o_rd_valid, bus_b.o_rd_data});
    end
    read_one(5'd3, ra, rb, ran);
    checks++;
    if (rb !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL inflight_after_b got %h want 1deadbeef", rb); end
  endtask

  task automatic test_reset_midop;
    int ca, cb, vp;
    logic [32:0] ra, rb, ran;
    $display("test_reset_midop");
    rd_cen = 1'b1; rd_addr = 5'd5;
    step();
    rd_cen = 1'b0;
    i_rstn = 1'b0;
    #1;
    checks++;
    if ({bus_a.o_rd_valid, bus_a.o_init_busy, bus_a.o_rd_data} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL midrst_a got %b/%b/%h want 0/1/0", bus_a.o_rd_valid, bus_a.o_init_busy, bus_a.o_rd_data);
    end
    checks++;
    if ({bus_b.o_rd_valid, bus_b.o_init_busy, bus_b.o_rd_data} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL midrst_b got %b/%b/%h want 0/1/0", bus_b.o_rd_valid, bus_b.o_init_busy, bus_b.o_rd_data);
    end
    vp = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus_a.o_rd_valid || bus_b.o_rd_valid) vp++;
    end
    checks++;
    if (vp !== 0) begin errors++; $display("FAIL midrst_valid got %0d pulses want 0", vp); end
    release_sweep(1'b0, ca, cb, vp);
    checks++;
    if (ca !== 32 || cb !== 32) begin errors++; $display("FAIL midrst_busy got %0d/%0d want 32/32", ca, cb); end
    read_one(5'd3, ra, rb, ran);
    checks++;
    if (ra !== {1'b1, 32'h0}) begin errors++; $display("FAIL midrst_addr3_a got %h want 100000000", ra); end
    checks++;
    if (rb !== {1'b1, 32'h0}) begin errors++; $display("FAIL midrst_addr3_b got %h want 100000000", rb); end
  endtask

  initial begin
    test_reset();
    test_init_requests();
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    test_back_to_back("sweep");
    test_byte_enables();
    test_rdw();
    test_inflight_write();
    for (int i = 0; i < 32; i++) begin
      do_write(5'(i), 32'(i), 4'hF);
      exp_mem[i] = 32'(i);
    end
    test_back_to_back("pipe");
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpsram.md
DPSRAM -- requirements
Module: dpsram

Interface
REQ-001 SHALL provide parameter BW_DATA, default 32, data width in bits; legal values are multiples of 8.
REQ-002 SHALL provide parameter BW_ADDR, default 5, address width; DEPTH = 2**BW_ADDR words.
REQ-003 SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL provide parameter WR_FIRST, default 1, read-during-write policy: 1 returns new data, 0 returns old data.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-006 SHALL have port i_clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-007 SHALL have port i_rstn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_wr_cen, input, 1 bit: write request.
REQ-009 SHALL have port i_wr_addr, input, BW_ADDR bits: write address.
REQ-010 SHALL have port i_wr_data, input, BW_DATA bits: write data.
REQ-011 SHALL have port i_wr_be, input, BW_DATA/8 bits: byte enables; bit k covers data bits [8k+7:8k].
REQ-012 SHALL have port i_rd_cen, input, 1 bit: read request.
REQ-013 SHALL have port i_rd_addr, input, BW_ADDR bits: read address.
REQ-014 SHALL have port o_rd_data, output, BW_DATA bits: read data.
REQ-015 SHALL have port o_rd_valid, output, 1 bit: o_rd_data holds a new read result this cycle.
REQ-016 SHALL have port o_init_busy, output, 1 bit: the clear sweep is in progress and requests are ignored.

Function
REQ-017 SHALL implement a 2-state FSM.
- INIT: entered on reset; a counter clears word 0..DEPTH-1, one word per cycle, with all bytes set to 0.
- READY: entered the cycle after the clear of word DEPTH-1.
- READY is terminal until the next reset.
REQ-018 SHALL assert o_init_busy in INIT only, for exactly DEPTH cycles after i_rstn deasserts.
REQ-019 SHALL ignore i_wr_cen and i_rd_cen while in INIT: no array write and no o_rd_valid pulse.
REQ-020 SHALL perform a write in READY on a rising edge with i_wr_cen=1.
- Only bytes with i_wr_be[k]=1 are updated.
- Other bytes keep their prior value.
- i_wr_be all-zero is a legal no-op.
REQ-021 SHALL capture a read in READY on a rising edge with i_rd_cen=1.
- o_rd_valid=1 and o_rd_data are driven exactly RD_LAT cycles after the capturing edge.
- Reads are fully pipelined: back-to-back reads give back-to-back valids.
REQ-022 SHALL hold o_rd_data at its last value while o_rd_valid=0.
REQ-023 SHALL handle a same-edge read and write to the same address as follows.
- WR_FIRST=1: return the merged word, with enabled bytes from i_wr_data and the other bytes from the prior contents.
- WR_FIRST=0: return the prior contents.
- Different addresses SHALL not interact.
REQ-024 SHALL, for RD_LAT=2, use a second output register stage.
- A write to the same address one cycle after the read capture SHALL NOT alter the in-flight result.
REQ-025 SHALL wrap addresses modulo DEPTH by width; there is no out-of-range condition.
REQ-026 SHALL leave array contents undefined only during reset; after INIT completes, every word reads 0 until written.

Reset
REQ-027 SHALL, while i_rstn=0, asynchronously force the following values.
- o_rd_data=0.
- o_rd_valid=0.
- Read pipeline valids cleared.
- FSM=INIT, clear counter=0.
- o_init_busy=1.
REQ-028 SHALL, on reset asserted mid-operation, drop all in-flight reads (no valid pulse) and restart the full clear sweep after deassertion.
REQ-029 SHALL require no reset of the storage array itself; the clear sweep provides the zeroing.

Verification
REQ-030 SHALL be checked for the clear sweep: release i_rstn with defaults -> o_init_busy high for exactly 32 cycles; then reading all 32 addresses returns 0 with o_rd_valid 1 cycle later.
REQ-031 SHALL be checked for byte enables: write 0xAABBCCDD to addr 3 with be=4'b1111, then write 0x11223344 to addr 3 with be=4'b0101, then read addr 3 -> 0xAA22CC44.
REQ-032 SHALL be checked for read-during-write: addr 7 holds 0x0, write 0xFFFFFFFF to addr 7 with be=4'b0011 while reading addr 7 on the same edge -> 0x0000FFFF with WR_FIRST=1, 0x00000000 with WR_FIRST=0.
REQ-033 SHALL be checked for read pipelining: with RD_LAT=2, issue reads of addr 0..31 on 32 consecutive cycles after writing data=addr -> o_rd_valid high for 32 consecutive cycles starting 2 cycles after the first read, with data 0..31 in order.
REQ-034 SHALL be checked for reset mid-operation: assert i_rstn=0 one cycle after a read capture -> o_rd_valid never pulses, o_rd_data=0 immediately; after release, o_init_busy high for 32 cycles and addr 3 reads 0.
REQ-035 SHALL be checked for requests during INIT: issue a write of 0x5 to addr 1 and a read during o_init_busy=1 -> no o_rd_valid pulse; after READY, addr 1 reads 0.
